// File: rtl/sobel_linebuf_if.sv
// sobel_linebuf_if: FIFO-side bundle for the Sobel line buffer.
//   fifo_in_*  : pop side of the pixel input FIFO (first-word-fall-through)
//   fifo_out_* : push side of the column-word output FIFO
// master: the line buffer (drives rd_en, wr_en, din)
// slave : the FIFO / environment side
interface sobel_linebuf_if #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
);
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;

  modport master (
    output fifo_in_rd_en,
    input  fifo_in_dout,
    input  fifo_in_empty,
    output fifo_out_wr_en,
    output fifo_out_din,
    input  fifo_out_full
  );

  modport slave (
    input  fifo_in_rd_en,
    output fifo_in_dout,
    output fifo_in_empty,
    input  fifo_out_wr_en,
    input  fifo_out_din,
    output fifo_out_full
  );
endinterface

// File: rtl/sobel_linebuf.sv
// sobel_linebuf: two-row line buffer ahead of the Sobel filter.
// Pops one raster pixel per accept and, once two rows of a frame are held,
// pushes a column word {row y, row y-1, row y-2} for the same x.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sobel_linebuf_if.master (input FIFO pop side, output FIFO push side)
module sobel_linebuf #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
) (
  input  logic              clock,
  input  logic              reset,
  sobel_linebuf_if.master   bus
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_t;

  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_out_valid;
  logic [DWIDTH_OUT-1:0] r_dout;

  // Line buffers are never reset: the FILL rows overwrite them before use.
  logic [DWIDTH_IN-1:0]  r_lb0 [0:WIDTH-1];   // row y-2
  logic [DWIDTH_IN-1:0]  r_lb1 [0:WIDTH-1];   // row y-1

  logic w_accept, w_wr_en, w_load, w_x_last, w_y_last;
  logic [DWIDTH_IN-1:0] w_lb0_rd, w_lb1_rd;

  // Reset gates both strobes so nothing is popped or pushed while reset is held.
  // In FILL a pending word cannot block input: FILL never loads the register.
  assign w_accept = !reset && !bus.fifo_in_empty &&
                    (r_state == FILL || !r_out_valid || !bus.fifo_out_full);
  assign w_wr_en  = !reset && r_out_valid && !bus.fifo_out_full;
  assign w_load   = w_accept && (r_state == STREAM);
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  assign w_lb0_rd = r_lb0[r_x];
  assign w_lb1_rd = r_lb1[r_x];

  assign bus.fifo_in_rd_en  = w_accept;
  assign bus.fifo_out_wr_en = w_wr_en;
  assign bus.fifo_out_din   = r_dout;

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lb0[r_x] <= w_lb1_rd;
      r_lb1[r_x] <= bus.fifo_in_dout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= FILL;
      r_x         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else begin
      if (w_accept) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        case (r_state)
          FILL:    if (w_x_last && r_y == YW'(1)) r_state <= STREAM;
          STREAM:  if (w_x_last && w_y_last)      r_state <= FILL;
          default: r_state <= FILL;
        endcase
      end
      // Load wins over drain: a same-cycle load and push keeps the flag set.
      if (w_load) begin
        r_dout      <= DWIDTH_OUT'({bus.fifo_in_dout, w_lb1_rd, w_lb0_rd});
        r_out_valid <= 1'b1;
      end else if (w_wr_en) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_linebuf.sv
module tb_sobel_linebuf;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sobel_linebuf_if #(.DWIDTH_IN(8), .DWIDTH_OUT(24)) bus ();

  sobel_linebuf #(.WIDTH(4), .HEIGHT(4), .DWIDTH_IN(8), .DWIDTH_OUT(24)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int nerr = 0;
  int nchk = 0;
  int ncyc = 0;
  int idx  = 0;
  logic [7:0]  src[$];
  logic [23:0] got[$];
  int          push_cyc[$];
  int          pop_cyc[$];
  logic        s_rd, s_wr;
  logic [23:0] s_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, then advance.
  task automatic cyc(input bit emp, input bit full);
    bus.fifo_in_empty = emp || (idx >= src.size());
    bus.fifo_in_dout  = (idx < src.size()) ? src[idx] : 8'h00;
    bus.fifo_out_full = full;
    #4;
    s_rd = bus.fifo_in_rd_en;
    s_wr = bus.fifo_out_wr_en;
    s_din = bus.fifo_out_din;
    if (s_wr) begin got.push_back(s_din); push_cyc.push_back(ncyc); end
    if (s_rd) begin pop_cyc.push_back(ncyc); idx++; end
    @(posedge clock); #1;
    ncyc++;
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < 16; i++) src.push_back(8'(base + i));
  endtask

  task automatic clear_all();
    src.delete(); got.delete(); push_cyc.delete(); pop_cyc.delete(); idx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0); cyc(0, 0);
    reset = 1'b0;
    clear_all();
  endtask

  // Column word k (0..7) of a 4x4 frame whose pixels are base, base+1, ...
  function automatic logic [23:0] exp_word(input int base, input int k);
    int y, x;
    y = 2 + k / 4;
    x = k % 4;
    return {8'(base + y*4 + x), 8'(base + (y-1)*4 + x), 8'(base + (y-2)*4 + x)};
  endfunction

  task automatic chk_frame(input string tag, input int base, input int off);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_w%0d", tag, k), (off + k < got.size()) ? 32'(got[off+k]) : 32'hDEAD,
          32'(exp_word(base, k)));
  endtask

  initial begin
    bus.fifo_in_empty = 1'b0;
    bus.fifo_in_dout  = 8'h55;
    bus.fifo_out_full = 1'b0;
    src.push_back(8'h55);

    // Reset held 3 cycles with input non-empty
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      chk($sformatf("rst_rd%0d", i), 32'(s_rd), 32'd0);
      chk($sformatf("rst_wr%0d", i), 32'(s_wr), 32'd0);
      chk($sformatf("rst_din%0d", i), 32'(s_din), 32'd0);
    end
    chk("rst_nopop", idx, 0);
    reset = 1'b0;
    cyc(0, 0);
    chk("first_pop_after_rst", 32'(s_rd), 32'd1);

    // Fill then stream, back to back
    do_reset();
    load_frame(1);
    for (int i = 0; i < 20; i++) cyc(0, 0);
    chk("s2_pushes", got.size(), 8);
    chk("s2_pops", idx, 16);
    chk_frame("s2", 1, 0);
    chk("s2_first", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'h090501);
    chk("s2_last", (got.size() > 7) ? 32'(got[7]) : 32'hDEAD, 32'h100C08);
    if (got.size() > 0 && pop_cyc.size() > 8)
      chk("s2_latency", push_cyc[0], pop_cyc[8] + 1);
    if (pop_cyc.size() == 16)
      chk("s2_throughput", pop_cyc[15] - pop_cyc[0], 15);

    // Backpressure: full for 5 cycles once 0x0A0602 is loaded
    do_reset();
    load_frame(1);
    for (int i = 0; i < 20 && idx < 10; i++) cyc(0, 0);
    chk("s3_idx", idx, 10);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1);
      chk($sformatf("s3_rd%0d", i), 32'(s_rd), 32'd0);
      chk($sformatf("s3_wr%0d", i), 32'(s_wr), 32'd0);
      chk($sformatf("s3_din%0d", i), 32'(s_din), 32'h0A0602);
    end
    chk("s3_held_pushes", got.size(), 1);
    for (int i = 0; i < 12; i++) cyc(0, 0);
    chk("s3_pushes", got.size(), 8);
    chk_frame("s3", 1, 0);

    // Random empty gaps
    do_reset();
    load_frame(1);
    for (int i = 0; i < 100; i++) cyc(1'($urandom_range(0, 1)), 0);
    chk("s4_pops", idx, 16);
    chk("s4_pushes", got.size(), 8);
    chk_frame("s4", 1, 0);

    // Frame wrap straight into a second frame
    do_reset();
    load_frame(1);
    load_frame(101);
    for (int i = 0; i < 36; i++) cyc(0, 0);
    chk("s5_pushes", got.size(), 16);
    chk_frame("s5a", 1, 0);
    chk_frame("s5b", 101, 8);
    chk("s5_first2", (got.size() > 8) ? 32'(got[8]) : 32'hDEAD, 32'h6D6965);
    if (pop_cyc.size() == 32) chk("s5_nobubble", pop_cyc[16], pop_cyc[15] + 1);
    if (push_cyc.size() == 16 && pop_cyc.size() == 32)
      chk("s5_latency2", push_cyc[8], pop_cyc[24] + 1);

    // Reset mid-frame with a word pending behind full
    do_reset();
    load_frame(1);
    for (int i = 0; i < 20 && idx < 10; i++) cyc(0, 0);
    cyc(1, 1);
    chk("s6_pending", 32'(s_din), 32'h0A0602);
    reset = 1'b1;
    cyc(1, 0); cyc(1, 0);
    chk("s6_rst_din", 32'(s_din), 32'd0);
    reset = 1'b0;
    cyc(1, 0);
    chk("s6_dropped", got.size(), 1);
    clear_all();
    load_frame(1);
    for (int i = 0; i < 20; i++) cyc(0, 0);
    chk("s6_pushes", got.size(), 8);
    chk_frame("s6", 1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
